// File: rtl/fcnn_pkg.sv
// Shared definitions for the network front end: default stream geometry,
// pixel-sender state encoding and a constant-function log2 helper.
package fcnn_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_WORDS_DEF  = 784;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SEND  = 2'd2
  } tx_state_e;

  // Address bits needed to index 'value' entries (at least 1).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_ram.sv
// Single-port-write / single-port-read frame buffer with a registered read
// output; the array itself is never reset, only the read register.
module pixel_ram
  import fcnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int ADDR_WIDTH = clog2(NUM_WORDS)
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge s_axi_aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: holds its value when rd_en is low so stalled beats stay put.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_pixel_sender.sv
// AXI-Stream master replaying one buffered frame of pixel words into the
// network input. Optional continuous replay: define PIXEL_SENDER_LOOP_EN.
module axis_pixel_sender
  import fcnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WORDS  = NUM_WORDS_DEF,
  parameter int ADDR_WIDTH = clog2(NUM_WORDS)
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic                  start,
`ifdef PIXEL_SENDER_LOOP_EN
  input  logic                  loop,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  wr_drop,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH:0] NUM_WORDS_L = (ADDR_WIDTH+1)'(NUM_WORDS);

  tx_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] index, index_nxt;
  logic [ADDR_WIDTH:0]   len, len_nxt;
  logic [ADDR_WIDTH:0]   len_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic                  done_nxt;
  logic                  hs;
  logic                  last_beat;
  logic                  loop_en;
  logic                  wr_in_range;
  logic                  ram_we;

`ifdef PIXEL_SENDER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign len_req     = (frame_len > NUM_WORDS_L) ? NUM_WORDS_L : frame_len;
  assign wr_in_range = ({1'b0, wr_addr} < NUM_WORDS_L);
  assign ram_we      = wr_en & ~busy & wr_in_range;

  // Stream outputs decode straight from registered state, so they only move on edges.
  assign busy          = (state != ST_IDLE);
  assign m_axis_tvalid = (state == ST_SEND);
  assign last_beat     = ({1'b0, index} == (len - 1'b1));
  assign m_axis_tlast  = m_axis_tvalid & last_beat;
  assign hs            = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    len_nxt   = len;
    done_nxt  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = index;
    case (state)
      ST_IDLE: begin
        if (start) begin
          len_nxt   = len_req;
          index_nxt = '0;
          if (len_req == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        rd_en     = 1'b1;
        rd_addr   = '0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        // Re-reading the current index while stalled keeps tdata stable.
        rd_en = 1'b1;
        if (hs) begin
          if (last_beat) begin
            done_nxt  = 1'b1;
            index_nxt = '0;
            rd_addr   = '0;
            if (loop_en && (len_req != '0)) begin
              len_nxt = len_req;
            end else begin
              rd_en     = 1'b0;
              state_nxt = ST_IDLE;
            end
          end else begin
            index_nxt = index + 1'b1;
            rd_addr   = index + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      index   <= '0;
      len     <= '0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state <= state_nxt;
      index <= index_nxt;
      len   <= len_nxt;
      done  <= done_nxt;
      if (wr_en && busy && wr_in_range) begin
        wr_drop <= 1'b1;
      end
    end
  end

  pixel_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .s_axi_aclk (s_axi_aclk),
    .reset      (reset),
    .wr_en      (ram_we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (m_axis_tdata)
  );

endmodule

// File: tb/tb_axis_pixel_sender.sv
// Directed bench for axis_pixel_sender: frame replay, backpressure, zero
// length, dropped writes, mid-frame reset, over-length and optional looping.
module tb_axis_pixel_sender;

  localparam int DW = 16;
  localparam int NW = 784;
  localparam int AW = 10;

  logic          s_axi_aclk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   frame_len = '0;
  logic          start = 1'b0;
  logic          busy, done, wr_drop;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
`ifdef PIXEL_SENDER_LOOP_EN
  logic          loop = 1'b0;
`endif

  always #5 s_axi_aclk = ~s_axi_aclk;

  axis_pixel_sender #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_WIDTH(AW)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_len     (frame_len),
    .start         (start),
`ifdef PIXEL_SENDER_LOOP_EN
    .loop          (loop),
`endif
    .busy          (busy),
    .done          (done),
    .wr_drop       (wr_drop),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  int tests = 0;
  int fails = 0;

  // Monitor results filled by collect().
  int q_data[$];
  bit q_last[$];
  int first_valid, done_cnt, done_cyc, last_hs_cyc, stall_viol;
  bit busy_seen, timed_out;

  task automatic tick();
    @(negedge s_axi_aclk);
  endtask

  // Drives tready (pat 0: always ready, pat 1: 1,0,0 repeating) and records
  // every handshaked beat; cycle 1 is the first negedge after start was set.
  task automatic collect(input int max_cycles, input int pat, input int tail);
    int rc;
    int tail_left;
    bit pv, pr, rdy;
    logic [DW-1:0] pd;
    logic pl;
    rc = 0; tail_left = -1; pv = 0; pr = 0; pd = '0; pl = 0;
    q_data.delete(); q_last.delete();
    first_valid = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    stall_viol = 0; busy_seen = 0; timed_out = 1;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      tick();
      if (cyc == 1) start = 1'b0;
      if (busy) busy_seen = 1;
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (pv && !pr && (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl))
        stall_viol++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (tail_left < 0) tail_left = tail;
      end
      rdy = (pat == 0) ? 1'b1 : ((rc % 3) == 0);
      rc++;
      m_axis_tready = rdy;
      if (m_axis_tvalid && rdy) begin
        q_data.push_back(int'(m_axis_tdata));
        q_last.push_back(m_axis_tlast);
        last_hs_cyc = cyc;
      end
      pv = m_axis_tvalid; pr = rdy; pd = m_axis_tdata; pl = m_axis_tlast;
      if (tail_left == 0) begin
        timed_out = 0;
        break;
      end
      if (tail_left > 0) tail_left--;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic load_buffer();
    for (int a = 0; a < NW; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a * 3);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", done); end
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL reset_wr_drop: got %0b want 0", wr_drop); end
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %0b want 0", m_axis_tvalid); end
    tests++; if (m_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_tlast: got %0b want 0", m_axis_tlast); end
    tests++; if (m_axis_tdata !== '0) begin fails++; $display("FAIL reset_tdata: got %0h want 0", m_axis_tdata); end
  endtask

  task automatic test_full_frame();
    frame_len = 11'd784; start = 1'b1;
    collect(2000, 0, 2);
    tests++; if (timed_out) begin fails++; $display("FAIL full_timeout: no done within budget"); end
    tests++; if (q_data.size() != 784) begin fails++; $display("FAIL full_beats: got %0d want 784", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 784; k++) begin
      tests++;
      if (q_data[k] != k * 3 || q_last[k] != (k == 783)) begin
        fails++;
        $display("FAIL full_beat%0d: got data %0d last %0b want data %0d last %0b", k, q_data[k], q_last[k], k * 3, (k == 783));
      end
    end
    tests++; if (first_valid != 2) begin fails++; $display("FAIL full_first_valid: got cycle %0d want 2", first_valid); end
    tests++; if (done_cyc != last_hs_cyc + 1) begin fails++; $display("FAIL full_done_time: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL full_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    frame_len = 11'd5; start = 1'b1;
    collect(200, 1, 2);
    tests++; if (q_data.size() != 5) begin fails++; $display("FAIL bp_beats: got %0d want 5", q_data.size()); end
    for (int k = 0; k < q_data.size() && k < 5; k++) begin
      tests++;
      if (q_data[k] != k * 3 || q_last[k] != (k == 4)) begin
        fails++;
        $display("FAIL bp_beat%0d: got data %0d last %0b want data %0d last %0b", k, q_data[k], q_last[k], k * 3, (k == 4));
      end
    end
    tests++; if (stall_viol != 0) begin fails++; $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_len();
    frame_len = 11'd0; start = 1'b1;
    collect(20, 0, 4);
    tests++; if (first_valid != -1) begin fails++; $display("FAIL zero_tvalid: got valid at cycle %0d want none", first_valid); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    tests++; if (done_cyc != 1) begin fails++; $display("FAIL zero_done_time: got %0d want 1", done_cyc); end
    tests++; if (busy_seen) begin fails++; $display("FAIL zero_busy: got 1 want 0"); end
  endtask

  task automatic test_wr_drop();
    frame_len = 11'd10; m_axis_tready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 10'd2; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    tests++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL drop_set: got %0b want 1", wr_drop); end
    collect(100, 0, 2);
    tests++; if (q_data.size() != 10 || q_data[2] != 6) begin fails++; $display("FAIL drop_frame1: got %0d beats, beat2 %0d want 10 beats, beat2 6", q_data.size(), (q_data.size() > 2) ? q_data[2] : -1); end
    start = 1'b1;
    collect(100, 0, 2);
    tests++; if (q_data.size() != 10 || q_data[2] != 6) begin fails++; $display("FAIL drop_frame2: got %0d beats, beat2 %0d want 10 beats, beat2 6", q_data.size(), (q_data.size() > 2) ? q_data[2] : -1); end
    tests++; if (wr_drop !== 1'b1) begin fails++; $display("FAIL drop_sticky: got %0b want 1", wr_drop); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL drop_clear: got %0b want 0", wr_drop); end
    wr_en = 1'b1; wr_addr = 10'd900; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    tests++; if (wr_drop !== 1'b0) begin fails++; $display("FAIL drop_oob: got %0b want 0", wr_drop); end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    frame_len = 11'd10; m_axis_tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    tests++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd9) begin fails++; $display("FAIL mid_beat3: got valid %0b data %0d want 1 9", m_axis_tvalid, m_axis_tdata); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_abort: got valid %0b busy %0b want 0 0", m_axis_tvalid, busy); end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    tests++; if (done_seen != 0) begin fails++; $display("FAIL mid_no_done: got %0d pulses want 0", done_seen); end
    start = 1'b1;
    collect(100, 0, 2);
    tests++; if (q_data.size() != 10 || q_data[0] != 0 || q_data[9] != 27) begin fails++; $display("FAIL mid_replay: got %0d beats first %0d want 10 beats first 0 last 27", q_data.size(), (q_data.size() > 0) ? q_data[0] : -1); end
  endtask

  task automatic test_overlength();
    frame_len = 11'd1000; start = 1'b1;
    collect(2000, 0, 2);
    tests++; if (q_data.size() != 784) begin fails++; $display("FAIL over_beats: got %0d want 784", q_data.size()); end
    tests++; if (q_data.size() == 784 && (q_last[783] != 1'b1 || q_last[782] != 1'b0 || q_data[783] != 2349)) begin
      fails++; $display("FAIL over_last: got last %0b data %0d want last 1 data 2349", q_last[783], q_data[783]);
    end
  endtask

`ifdef PIXEL_SENDER_LOOP_EN
  task automatic test_loop();
    int beats, gap, dn, w785;
    beats = 0; gap = 0; dn = 0; w785 = -1;
    loop = 1'b1; frame_len = 11'd1000; m_axis_tready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      tick();
      if (cyc == 1) start = 1'b0;
      if (cyc >= 2 && busy && !m_axis_tvalid) gap++;
      if (done) dn++;
      if (m_axis_tvalid) begin
        if (beats == 784) w785 = int'(m_axis_tdata);
        beats++;
        if (beats == 790) loop = 1'b0;
      end
      if (cyc > 2 && !busy) break;
    end
    tests++; if (w785 != 0) begin fails++; $display("FAIL loop_wrap_word: got %0d want 0", w785); end
    tests++; if (gap != 0) begin fails++; $display("FAIL loop_gap: got %0d idle cycles want 0", gap); end
    tests++; if (beats != 1568) begin fails++; $display("FAIL loop_beats: got %0d want 1568", beats); end
    tests++; if (dn != 2) begin fails++; $display("FAIL loop_done_cnt: got %0d want 2", dn); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    load_buffer();
    test_full_frame();
    test_backpressure();
    test_zero_len();
    test_wr_drop();
    test_reset_mid();
    test_overlength();
`ifdef PIXEL_SENDER_LOOP_EN
    test_loop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_pixel_sender.md
Name: axis_pixel_sender

Overview:
- AXI-Stream master that feeds input vectors into the network's slave stream port (data/valid/ready).
- Holds one frame of pixel words in an internal buffer. The buffer is loaded word-by-word from the AXI-Lite register side.
- On start, streams the first `frame_len` words at full throughput, with tlast on the final beat.
- Sits between the processor-facing register block and the network input.

Parameters:
- DATA_WIDTH, 16, width of one pixel/stream word (matches network dataWidth)
- NUM_WORDS, 784, buffer depth in words (matches layer-1 weight count)
- ADDR_WIDTH, 10, buffer address width; must satisfy 2**ADDR_WIDTH >= NUM_WORDS

Ports:
- s_axi_aclk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  buffer write strobe
- wr_addr  in  ADDR_WIDTH  buffer write address
- wr_data  in  DATA_WIDTH  buffer write data
- frame_len  in  ADDR_WIDTH+1  words per frame, sampled at start
- start  in  1  begin transmission (level, sampled in IDLE only)
- busy  out  1  high from accepted start until final beat accepted
- done  out  1  one-cycle pulse after final beat handshake
- wr_drop  out  1  sticky: a write was discarded while busy; cleared by reset
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  final beat of frame

Behaviour:
- Reset values: busy=0, done=0, wr_drop=0, tvalid=0, tlast=0, tdata=0, state=IDLE, index=0. Buffer contents are not cleared.
- Reset mid-frame: tvalid falls on the next edge and the frame is abandoned; no done pulse.
- Buffer: synchronous write, synchronous read with 1-cycle latency. tdata is the registered read output.
- Writes are accepted only in IDLE.
  - wr_en while busy: write dropped, wr_drop set.
  - wr_addr >= NUM_WORDS: write ignored, wr_drop unaffected.
- Length: len = min(frame_len, NUM_WORDS), latched when start is accepted.
- States:
  - IDLE: if start and len==0, pulse done next cycle, stay IDLE, no beat emitted. If start and len>0, go to PRIME with index=0 and busy=1.
  - PRIME: read address 0 presented. Next state is SEND with tvalid=1.
  - SEND: read address = index+1 when (tvalid & tready) else index, so tdata stays stable under backpressure.
    - Handshake on a non-final beat: index increments.
    - tlast = (index == len-1).
    - Handshake with tlast: go to IDLE, tvalid=0, busy=0, done=1 for one cycle.
- Latency: start high in cycle 0, PRIME in cycle 1, first tvalid in cycle 2.
- With tready held high: one beat per cycle, len beats, frame occupies len+1 cycles from PRIME.
- AXIS rules:
  - tvalid never deasserts without a handshake.
  - tdata and tlast are held constant while tvalid & ~tready.
- start while busy: ignored, no queueing.
- start held high across done: a new frame starts on the cycle done is high (IDLE re-samples start).

Optional Feature:
- Macro PIXEL_SENDER_LOOP_EN.
- Defined: adds input port loop (1 bit).
  - If loop=1 at the final-beat handshake, the FSM returns to SEND with index=0.
  - Read address 0 is presented in the same cycle, so there is no gap.
  - done pulses per frame; busy stays high.
  - len is re-latched from frame_len at each wrap.
- Undefined: no loop port; behaviour exactly as above.

Decomposition:
- Shared package `fcnn_pkg`: DATA_WIDTH/NUM_WORDS defaults, 2-bit state encoding (IDLE=0, PRIME=1, SEND=2), and a clog2 helper for ADDR_WIDTH.
- One sub-module, `pixel_ram`: single write port, single synchronous read port, depth NUM_WORDS, no reset on array.
- FSM, counters and handshake logic live in the top.

Test Plan:
- Load words 0..783 with value addr*3, frame_len=784, tready=1, pulse start → 784 beats with tdata 0,3,…,2349, tlast only on beat 784, first tvalid 2 cycles after start, done 1 cycle after last beat.
- frame_len=5, tready toggling 1,0,0,1,… → tdata/tlast stable during stalls, exactly 5 beats in order, no duplicates or skips.
- frame_len=0, start → no tvalid ever, done pulses once, busy stays 0.
- wr_en at addr 2 with 0xBEEF during busy → wr_drop=1, frame 2's beat 2 returns the old value; reset clears wr_drop.
- Assert reset at beat 3 of a 10-word frame → tvalid=0 next cycle, no done; fresh start replays from word 0.
- frame_len=1000 (>NUM_WORDS) → 784 beats, tlast on beat 784; with PIXEL_SENDER_LOOP_EN and loop=1, beat 785 is word 0 with no idle cycle.
